engine_divide_multi: RTL and testbench

ENGINE_DIVIDE_MULTI -- requirements
Module: engine_divide_multi

---
 rtl/engine_divide_multi_if.sv | 32 +++
 rtl/engine_divide_multi.sv | 174 +++++++++++++++++
 tb/tb_engine_divide_multi.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/engine_divide_multi_if.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : engine_divide_multi_if                                     |
// | Function : Request/result bundle for the multi-step divider engine.   |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
interface engine_divide_multi_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] numerator;
    logic [WIDTH-1:0] denominator;
    logic             signed_op;
    logic             go;
    logic             abort;
    logic             busy;
    logic             result_valid;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output numerator, denominator, signed_op, go, abort,
        input  busy, result_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  numerator, denominator, signed_op, go, abort,
        output busy, result_valid, quotient, remainder, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/engine_divide_multi.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : engine_divide_multi                                        |
// | Function : Restoring signed/unsigned divider, STEPS bits per cycle.   |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module engine_divide_multi #(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input  wire logic            clock,
    input  wire logic            clock_areset_n,
    engine_divide_multi_if.slave bus
);
    localparam int N  = WIDTH / STEPS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 4 || !(STEPS == 1 || STEPS == 2 || STEPS == 4) || (WIDTH % STEPS) != 0) begin : g_bad_params
            $error("engine_divide_multi: illegal WIDTH/STEPS combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic [CW-1:0]    count_q,    count_d;
    logic [WIDTH-1:0] rem_q,      rem_d;
    logic [WIDTH-1:0] quo_q,      quo_d;
    logic [WIDTH-1:0] den_q,      den_d;
    logic             qneg_q,     qneg_d;
    logic             rneg_q,     rneg_d;
    logic             zero_q,     zero_d;
    logic             busy_q,     busy_d;
    logic             valid_q,    valid_d;
    logic [WIDTH-1:0] quot_out_q, quot_out_d;
    logic [WIDTH-1:0] rem_out_q,  rem_out_d;
    logic             dbz_out_q,  dbz_out_d;

    logic [WIDTH-1:0] num_mag;
    logic [WIDTH-1:0] den_mag;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH:0]   trial;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        den_d      = den_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        zero_d     = zero_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        quot_out_d = quot_out_q;
        rem_out_d  = rem_out_q;
        dbz_out_d  = dbz_out_q;

        // Unsigned negation keeps -2^(WIDTH-1) as the exact magnitude 2^(WIDTH-1).
        num_mag = (bus.signed_op && bus.numerator[WIDTH-1])   ? -bus.numerator   : bus.numerator;
        den_mag = (bus.signed_op && bus.denominator[WIDTH-1]) ? -bus.denominator : bus.denominator;

        step_rem = rem_q;
        step_quo = quo_q;
        trial    = '0;
        for (int i = 0; i < STEPS; i++) begin
            trial    = {step_rem, step_quo[WIDTH-1]};
            step_quo = {step_quo[WIDTH-2:0], 1'b0};
            if (trial >= {1'b0, den_q}) begin
                trial       = trial - {1'b0, den_q};
                step_quo[0] = 1'b1;
            end
            step_rem = trial[WIDTH-1:0];
        end

        case (state_q)
            IDLE: begin
                if (bus.go && !bus.abort) begin
                    busy_d  = 1'b1;
                    count_d = CW'(N - 1);
                    qneg_d  = bus.signed_op & (bus.numerator[WIDTH-1] ^ bus.denominator[WIDTH-1]);
                    rneg_d  = bus.signed_op & bus.numerator[WIDTH-1];
                    if (bus.denominator == '0) begin
                        // Zero divisor skips iteration; raw numerator is parked in rem_q.
                        zero_d  = 1'b1;
                        rem_d   = bus.numerator;
                        quo_d   = '1;
                        state_d = FIX;
                    end else begin
                        zero_d  = 1'b0;
                        rem_d   = '0;
                        quo_d   = num_mag;
                        den_d   = den_mag;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (bus.abort) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    if (count_q == '0) begin
                        state_d = FIX;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            end
            FIX: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (!bus.abort) begin
                    quot_out_d = (!zero_q && qneg_q) ? -quo_q : quo_q;
                    rem_out_d  = (!zero_q && rneg_q) ? -rem_q : rem_q;
                    dbz_out_d  = zero_q;
                    valid_d    = 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            den_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            zero_q     <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            quot_out_q <= '0;
            rem_out_q  <= '0;
            dbz_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            den_q      <= den_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            zero_q     <= zero_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            quot_out_q <= quot_out_d;
            rem_out_q  <= rem_out_d;
            dbz_out_q  <= dbz_out_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.result_valid = valid_q;
    assign bus.quotient     = quot_out_q;
    assign bus.remainder    = rem_out_q;
    assign bus.div_by_zero  = dbz_out_q;
endmodule
`default_nettype wire

// File: tb/tb_engine_divide_multi.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_engine_divide_multi                                     |
// | Function : Bench for engine_divide_multi, STEPS=1 and STEPS=4 copies. |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_engine_divide_multi;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  go_v = '0;
    logic [1:0]  abort_v = '0;
    logic [1:0]  sgn_v = '0;
    logic [31:0] num_v [2];
    logic [31:0] den_v [2];
    logic [1:0]  busy_v, vld_v, dbz_v;
    logic [31:0] q_v [2];
    logic [31:0] r_v [2];

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    engine_divide_multi_if #(.WIDTH(32)) if0 ();
    engine_divide_multi_if #(.WIDTH(32)) if1 ();

    engine_divide_multi #(.WIDTH(32), .STEPS(1)) u_dut0 (.clock(clk), .clock_areset_n(rst_n), .bus(if0));
    engine_divide_multi #(.WIDTH(32), .STEPS(4)) u_dut1 (.clock(clk), .clock_areset_n(rst_n), .bus(if1));

    assign if0.numerator = num_v[0];  assign if1.numerator = num_v[1];
    assign if0.denominator = den_v[0]; assign if1.denominator = den_v[1];
    assign if0.signed_op = sgn_v[0];  assign if1.signed_op = sgn_v[1];
    assign if0.go = go_v[0];          assign if1.go = go_v[1];
    assign if0.abort = abort_v[0];    assign if1.abort = abort_v[1];
    assign busy_v = {if1.busy, if0.busy};
    assign vld_v  = {if1.result_valid, if0.result_valid};
    assign dbz_v  = {if1.div_by_zero, if0.div_by_zero};
    assign q_v[0] = if0.quotient;  assign q_v[1] = if1.quotient;
    assign r_v[0] = if0.remainder; assign r_v[1] = if1.remainder;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: 64-bit signed ops give truncation toward zero and natural wrap.
    function automatic logic [63:0] model_div(input logic [31:0] n, input logic [31:0] dn, input logic s);
        longint a, b;
        if (dn == 32'd0) return {32'hFFFF_FFFF, n};
        if (s) begin
            a = longint'($signed(n));
            b = longint'($signed(dn));
            return {32'(a / b), 32'(a % b)};
        end
        return {n / dn, n % dn};
    endfunction

    function automatic int n_of(input int d);
        return (d == 0) ? 32 : 8;
    endfunction

    // Transaction-level model: a result appears N+2 edges after acceptance (2 for zero divisor).
    logic [1:0]  m_busy, m_valid, m_dbz, p_dbz;
    logic [31:0] m_q [2];
    logic [31:0] m_r [2];
    logic [31:0] p_q [2];
    logic [31:0] p_r [2];
    int          m_left [2];

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_busy[d] <= 1'b0; m_valid[d] <= 1'b0; m_dbz[d] <= 1'b0;
                m_q[d] <= '0; m_r[d] <= '0; m_left[d] <= 0;
            end else begin
                m_valid[d] <= 1'b0;
                if (m_busy[d]) begin
                    if (abort_v[d]) begin
                        m_busy[d] <= 1'b0;
                    end else if (m_left[d] == 1) begin
                        m_busy[d] <= 1'b0; m_valid[d] <= 1'b1;
                        m_q[d] <= p_q[d]; m_r[d] <= p_r[d]; m_dbz[d] <= p_dbz[d];
                    end else begin
                        m_left[d] <= m_left[d] - 1;
                    end
                end else if (go_v[d] && !abort_v[d]) begin
                    {p_q[d], p_r[d]} <= model_div(num_v[d], den_v[d], sgn_v[d]);
                    p_dbz[d]  <= (den_v[d] == 32'd0);
                    m_busy[d] <= 1'b1;
                    m_left[d] <= (den_v[d] == 32'd0) ? 1 : n_of(d) + 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("cyc_busy%0d", d), busy_v[d], m_busy[d]);
                chk($sformatf("cyc_valid%0d", d), vld_v[d], m_valid[d]);
                chk($sformatf("cyc_quot%0d", d), q_v[d], m_q[d]);
                chk($sformatf("cyc_rem%0d", d), r_v[d], m_r[d]);
                chk($sformatf("cyc_dbz%0d", d), dbz_v[d], m_dbz[d]);
            end
        end
    end

    task automatic do_op(input int d, input logic [31:0] n, input logic [31:0] dn, input logic s,
                         input int exp_lat, input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                         input string name);
        int lat;
        @(negedge clk);
        num_v[d] = n; den_v[d] = dn; sgn_v[d] = s; go_v[d] = 1'b1;
        @(posedge clk); #1; lat = 1;
        @(negedge clk); go_v[d] = 1'b0;
        while (!vld_v[d] && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        chk({name, "_lat"}, lat, exp_lat);
        chk({name, "_q"}, q_v[d], eq);
        chk({name, "_r"}, r_v[d], er);
        chk({name, "_dbz"}, dbz_v[d], edbz);
    endtask

    task automatic count_valid(input int d, input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (vld_v[d]) cnt++;
        end
    endtask

    initial begin
        int cnt, pulses, lat;
        int pos [4];
        num_v[0] = '0; num_v[1] = '0; den_v[0] = '0; den_v[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", busy_v[d], 1'b0);
            chk("rst_valid", vld_v[d], 1'b0);
            chk("rst_q", q_v[d], 32'd0);
            chk("rst_r", r_v[d], 32'd0);
            chk("rst_dbz", dbz_v[d], 1'b0);
        end
        @(negedge clk); rst_n = 1'b1; chk_en = 1'b1;

        do_op(0, 32'd100, 32'd7, 1'b0, 34, 32'd14, 32'd2, 1'b0, "u100_7");
        do_op(1, 32'hFFFF_FFF9, 32'd2, 1'b1, 10, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "sm7_2");
        do_op(1, 32'd7, 32'hFFFF_FFFE, 1'b1, 10, 32'hFFFF_FFFD, 32'd1, 1'b0, "s7_m2");
        do_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 10, 32'h8000_0000, 32'd0, 1'b0, "sovf");
        do_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10, 32'd0, 32'h8000_0000, 1'b0, "uovf");
        do_op(1, 32'h1234_5678, 32'd0, 1'b1, 2, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, "sdbz");
        do_op(1, 32'h1234_5678, 32'd0, 1'b0, 2, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, "udbz");
        do_op(0, 32'h8765_4321, 32'd0, 1'b1, 2, 32'hFFFF_FFFF, 32'h8765_4321, 1'b1, "sdbz_neg");
        do_op(0, 32'hFFFF_FF9C, 32'd7, 1'b1, 34, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, "sm100_7");
        do_op(0, 32'hFFFF_FFFF, 32'd1, 1'b0, 34, 32'hFFFF_FFFF, 32'd0, 1'b0, "umax_1");
        do_op(0, 32'd100, 32'd7, 1'b0, 34, 32'd14, 32'd2, 1'b0, "u100_7b");

        // go held continuously: results at edges 10, 20, 30 counting the first accept as edge 1.
        @(negedge clk);
        num_v[1] = 32'd1000; den_v[1] = 32'd3; sgn_v[1] = 1'b0; go_v[1] = 1'b1;
        pulses = 0;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk); #1;
            if (vld_v[1]) begin
                if (pulses < 4) pos[pulses] = e;
                pulses++;
                chk("b2b_q", q_v[1], 32'd333);
            end
        end
        @(negedge clk); go_v[1] = 1'b0;
        chk("b2b_pulses", pulses, 3);
        chk("b2b_pos0", pos[0], 10);
        chk("b2b_pos1", pos[1], 20);
        chk("b2b_pos2", pos[2], 30);
        count_valid(1, 15, cnt);
        chk("b2b_tail", cnt, 0);

        // go pulse with different operands while busy must be ignored.
        @(negedge clk); num_v[1] = 32'd1001; den_v[1] = 32'd4; go_v[1] = 1'b1;
        @(negedge clk); go_v[1] = 1'b0;
        repeat (3) @(negedge clk);
        num_v[1] = 32'd9; den_v[1] = 32'd3; go_v[1] = 1'b1;
        @(negedge clk); go_v[1] = 1'b0;
        lat = 0;
        while (!vld_v[1] && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        chk("busy_go_q", q_v[1], 32'd250);
        chk("busy_go_r", r_v[1], 32'd1);
        count_valid(1, 20, cnt);
        chk("busy_go_extra", cnt, 0);

        // Abort on the fifth CALC edge.
        @(negedge clk); num_v[0] = 32'd5000; den_v[0] = 32'd3; sgn_v[0] = 1'b0; go_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk); go_v[0] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); abort_v[0] = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", busy_v[0], 1'b0);
        chk("abort_q_held", q_v[0], 32'd14);
        chk("abort_r_held", r_v[0], 32'd2);
        @(negedge clk); abort_v[0] = 1'b0;
        count_valid(0, 40, cnt);
        chk("abort_no_valid", cnt, 0);
        @(negedge clk); go_v[0] = 1'b1; abort_v[0] = 1'b1;
        @(posedge clk); #1;
        chk("idle_abort_block", busy_v[0], 1'b0);
        @(negedge clk); go_v[0] = 1'b0; abort_v[0] = 1'b0;
        do_op(0, 32'd5000, 32'd3, 1'b0, 34, 32'd1666, 32'd2, 1'b0, "post_abort");

        // Reset during the tenth CALC cycle.
        @(negedge clk); num_v[0] = 32'd5000; den_v[0] = 32'd7; go_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk); go_v[0] = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk("arst_busy", busy_v[0], 1'b0);
        chk("arst_valid", vld_v[0], 1'b0);
        chk("arst_q", q_v[0], 32'd0);
        chk("arst_r", r_v[0], 32'd0);
        chk("arst_dbz", dbz_v[0], 1'b0);
        chk("arst_q1", q_v[1], 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_valid(0, 50, cnt);
        chk("arst_no_valid", cnt, 0);
        do_op(0, 32'hFFFF_FF9C, 32'd7, 1'b1, 34, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, "post_rst");

        repeat (3) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
